// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch/data request ports and shared memory bus of the arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ready;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_ready, dm_rdata, dm_ready, mem_en, mem_we, mem_addr, mem_wdata
  );
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_ready, dm_rdata, dm_ready, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the fetch and data ports
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  mem_port_arbiter_if.slave bus,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int CW = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;
  state_t            state;
  logic [CW-1:0]     cnt;
  logic              last_dm;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              done;
  logic              grant_dm;
  logic              stall;
  always_comb begin
    busy          = state != IDLE;
    done          = busy && cnt == '0;
    grant_dm      = bus.dm_req && !(last_dm && bus.if_req);
    bus.if_ready  = done && state == BUSY_IF;
    bus.dm_ready  = done && state == BUSY_DM;
    bus.if_rdata  = bus.if_ready ? bus.mem_rdata : '0;
    bus.dm_rdata  = bus.dm_ready ? bus.mem_rdata : '0;
    bus.mem_en    = busy;
    bus.mem_we    = state == BUSY_DM && we_q;
    bus.mem_addr  = busy ? addr_q : '0;
    bus.mem_wdata = busy ? wdata_q : '0;
    stall         = (bus.if_req && !bus.if_ready) || (bus.dm_req && !bus.dm_ready);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      last_dm   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      stall_cnt <= '0;
    end else begin
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      case (state)
        IDLE: if (bus.dm_req || bus.if_req) begin
          state   <= grant_dm ? BUSY_DM : BUSY_IF;
          last_dm <= grant_dm;
          addr_q  <= grant_dm ? bus.dm_addr : bus.if_addr;
          we_q    <= grant_dm && bus.dm_we;
          wdata_q <= grant_dm ? bus.dm_wdata : '0;
          cnt     <= CW'(MEM_LAT - 1);
        end
        default: if (cnt != '0) cnt <= cnt - 1'b1; else state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized transactions checked against a timestamp-based reference
module tb_mem_port_arbiter;
  localparam int LAT = 2;
  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          gap;
  } txn_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus4 ();
  logic        busy, busy4;
  logic [15:0] stall_cnt;
  logic [3:0]  stall_cnt4;
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .stall_cnt(stall_cnt));
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4), .busy(busy4), .stall_cnt(stall_cnt4));
  assign bus4.if_req   = bus.if_req;
  assign bus4.if_addr  = bus.if_addr;
  assign bus4.dm_req   = bus.dm_req;
  assign bus4.dm_we    = bus.dm_we;
  assign bus4.dm_addr  = bus.dm_addr;
  assign bus4.dm_wdata = bus.dm_wdata;
  // memory: unwritten words read back as their byte address + 0x100
  bit [31:0] mem [256];
  bit        wr  [256];
  logic [7:0] ia, ia4;
  assign ia  = bus.mem_addr[9:2];
  assign ia4 = bus4.mem_addr[9:2];
  always_comb begin
    bus.mem_rdata = '0;
    if (bus.mem_en) bus.mem_rdata = wr[ia] ? mem[ia] : {22'b0, ia, 2'b00} + 32'h100;
  end
  always_comb begin
    bus4.mem_rdata = '0;
    if (bus4.mem_en) bus4.mem_rdata = wr[ia4] ? mem[ia4] : {22'b0, ia4, 2'b00} + 32'h100;
  end
  always @(posedge clk) if (bus.mem_en && bus.mem_we) begin
    mem[ia] <= bus.mem_wdata;
    wr[ia]  <= 1'b1;
  end
  function automatic logic [31:0] rd(logic [31:0] a);
    return wr[a[9:2]] ? mem[a[9:2]] : {22'b0, a[9:2], 2'b00} + 32'h100;
  endfunction
  int n_cmp = 0;
  int n_err = 0;
  txn_t qif[$], qdm[$];
  logic [32:0] log_q[$];
  bit aif, adm;
  int wif, wdm;
  // reference: current access (0 none, 1 fetch, 2 data) and the cycle number its ready is due
  int cyc, cur, done_at, stall;
  logic [31:0] cur_addr, cur_wdata;
  bit cur_we, last_dm, e_if, e_dm;
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic push(bit dm, logic [31:0] a, bit we, logic [31:0] wd, int gap);
    txn_t t;
    t.addr = a; t.we = we; t.wdata = wd; t.gap = gap;
    if (dm) qdm.push_back(t); else qif.push_back(t);
  endtask
  task automatic drive();
    if (!aif && qif.size() > 0) begin
      if (wif < qif[0].gap) wif++; else begin aif = 1; wif = 0; end
    end
    if (!adm && qdm.size() > 0) begin
      if (wdm < qdm[0].gap) wdm++; else begin adm = 1; wdm = 0; end
    end
    bus.if_req   = aif;
    bus.if_addr  = aif ? qif[0].addr : 32'h0;
    bus.dm_req   = adm;
    bus.dm_we    = adm ? qdm[0].we : 1'b0;
    bus.dm_addr  = adm ? qdm[0].addr : 32'h0;
    bus.dm_wdata = adm ? qdm[0].wdata : 32'h0;
  endtask
  task automatic check();
    bit b;
    b    = cur != 0;
    e_if = cur == 1 && cyc == done_at;
    e_dm = cur == 2 && cyc == done_at;
    chk("busy", busy, b);
    chk("mem_en", bus.mem_en, b);
    chk("mem_addr", bus.mem_addr, b ? cur_addr : 32'h0);
    chk("mem_we", bus.mem_we, cur == 2 && cur_we);
    if (cur != 1) chk("mem_wdata", bus.mem_wdata, cur == 2 ? cur_wdata : 32'h0);
    chk("if_ready", bus.if_ready, e_if);
    chk("if_rdata", bus.if_rdata, e_if ? rd(cur_addr) : 32'h0);
    chk("dm_ready", bus.dm_ready, e_dm);
    chk("dm_rdata", bus.dm_rdata, e_dm ? rd(cur_addr) : 32'h0);
    chk("stall_cnt", stall_cnt, stall > 65535 ? 65535 : stall);
    chk("stall_cnt4", stall_cnt4, stall > 15 ? 15 : stall);
    chk("ready4", {bus4.if_ready, bus4.dm_ready}, {e_if, e_dm});
    if (bus.if_ready === 1'b1) log_q.push_back({1'b0, bus.if_rdata});
    if (bus.dm_ready === 1'b1) log_q.push_back({1'b1, bus.dm_rdata});
  endtask
  task automatic update();
    if ((bus.if_req && !e_if) || (bus.dm_req && !e_dm)) stall++;
    if (e_if) begin aif = 0; void'(qif.pop_front()); end
    if (e_dm) begin adm = 0; void'(qdm.pop_front()); end
    if (cur != 0) begin
      if (cyc == done_at) cur = 0;
    end else if (bus.dm_req && !(last_dm && bus.if_req)) begin
      cur = 2; cur_addr = bus.dm_addr; cur_we = bus.dm_we; cur_wdata = bus.dm_wdata;
      last_dm = 1; done_at = cyc + LAT;
    end else if (bus.if_req) begin
      cur = 1; cur_addr = bus.if_addr; cur_we = 0; cur_wdata = 0;
      last_dm = 0; done_at = cyc + LAT;
    end
    cyc++;
  endtask
  task automatic tick();
    drive();
    @(negedge clk);
    check();
    @(posedge clk);
    update();
    #1;
  endtask
  task automatic drain(int bound);
    int n;
    n = 0;
    while ((qif.size() + qdm.size() != 0 || cur != 0) && n < bound) begin
      tick();
      n++;
    end
    n_cmp++;
    assert (n < bound) else begin
      n_err++;
      $error("FAIL drain: took %0d cycles, required under %0d", n, bound);
    end
  endtask
  initial begin
    cyc = 0; cur = 0; done_at = -1; stall = 0; last_dm = 0;
    aif = 0; adm = 0; wif = 0; wdm = 0;
    drive();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) tick();
    push(0, 32'h0, 0, 0, 0);
    push(0, 32'h4, 0, 0, 0);
    push(0, 32'h8, 0, 0, 0);
    drain(100);
    chk("if_stream_n", log_q.size(), 3);
    chk("if_stream_0", log_q[0], {1'b0, 32'h100});
    chk("if_stream_1", log_q[1], {1'b0, 32'h104});
    chk("if_stream_2", log_q[2], {1'b0, 32'h108});
    chk("if_stream_stall", stall_cnt, 6);
    log_q.delete();
    push(0, 32'h10, 0, 0, 0);
    push(1, 32'h40, 0, 0, 0);
    push(1, 32'h44, 0, 0, 0);
    drain(100);
    chk("simul_n", log_q.size(), 3);
    chk("simul_dm_first", log_q[0], {1'b1, 32'h140});
    chk("simul_if_second", log_q[1], {1'b0, 32'h110});
    chk("simul_dm_third", log_q[2], {1'b1, 32'h144});
    log_q.delete();
    push(1, 32'h20, 1, 32'hDEADBEEF, 0);
    push(1, 32'h20, 0, 0, 0);
    drain(100);
    chk("store_load_n", log_q.size(), 2);
    chk("store_load", log_q[1], {1'b1, 32'hDEADBEEF});
    log_q.delete();
    push(1, 32'h80, 0, 0, 0);
    tick();
    chk("abort_busy_before", bus.mem_en, 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_mem_en", bus.mem_en, 0);
    chk("abort_dm_ready", bus.dm_ready, 0);
    chk("abort_busy", busy, 0);
    chk("abort_addr", bus.mem_addr, 0);
    chk("abort_stall", stall_cnt, 0);
    cur = 0; last_dm = 0; stall = 0;
    @(posedge clk);
    cyc++;
    #1 rst = 1'b0;
    drain(100);
    chk("abort_regrant_n", log_q.size(), 1);
    chk("abort_regrant", log_q[0], {1'b1, 32'h180});
    for (int i = 0; i < 40; i++) begin
      push(0, {22'b0, 8'($urandom_range(0, 255)), 2'b00}, 0, 0, $urandom_range(0, 2));
      push(1, {22'b0, 8'($urandom_range(0, 255)), 2'b00}, 1'($urandom_range(0, 1)), $urandom,
           $urandom_range(0, 2));
    end
    drain(2000);
    chk("stall4_saturated", stall_cnt4, 15);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter that shares one single-ported unified instruction/data memory between the pipeline's instruction-fetch (IF) port and data-memory (MEM-stage) port. It sits between the pipelined CPU and the memory model. It grants one requester at a time, drives the memory for a fixed access latency, and returns per-port ready strobes that the pipeline uses as stall releases. It also keeps a saturating stall-cycle counter for performance inspection in simulation dumps.

## Interface
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports
- MEM_LAT, 2, memory access latency in cycles; legal range 1..16
- CNT_W, 16, width of the stall-cycle counter
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, asynchronous and active-high
- if_req  in  1  fetch request; held high with stable if_addr until if_ready
- if_addr  in  ADDR_W  fetch byte address
- if_rdata  out  DATA_W  fetch data; valid only while if_ready=1
- if_ready  out  1  fetch completes this cycle
- dm_req  in  1  data request; held high with stable dm_we/addr/wdata until dm_ready
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data byte address
- dm_wdata  in  DATA_W  store data
- dm_rdata  out  DATA_W  load data; valid only while dm_ready=1
- dm_ready  out  1  data access completes this cycle
- mem_en  out  1  memory access active
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data; valid in the final cycle of an access
- busy  out  1  arbiter not in IDLE
- stall_cnt  out  CNT_W  saturating count of cycles with a pending, not-ready request

## Operation
- States: IDLE, BUSY_IF, BUSY_DM. Down-counter cnt, width sized for MEM_LAT-1. last_dm flag records the port of the last grant.
- IDLE: at a rising edge with any request pending, grant one port. Latch that port's addr (plus we/wdata for DM). Load cnt = MEM_LAT-1. Enter BUSY_IF or BUSY_DM.
- Grant priority: DM wins a simultaneous request, except when last_dm=1 and if_req=1, in which case IF wins. This is the anti-starvation rule. On grant, last_dm is set to the granted port.
- BUSY_x: mem_en=1. mem_addr and mem_wdata come from the latches. mem_we = latched we in BUSY_DM and 0 in BUSY_IF.
  - cnt decrements each edge while cnt≠0.
  - When cnt=0, x_ready=1 combinationally and x_rdata = mem_rdata. At the next edge the FSM returns to IDLE.
- A stable request is never re-granted in the same edge it completes. IDLE always lasts at least one cycle between accesses, so the requester sees ready, advances at that edge, and presents its new request in the IDLE cycle.
- x_rdata is 0 whenever x_ready=0. mem_addr, mem_wdata and mem_we are 0 in IDLE.
- stall_cnt increments each cycle where (if_req & ~if_ready) | (dm_req & ~dm_ready). It saturates at all-ones.
- Requests that drop before ready are a protocol violation. The arbiter completes the latched access regardless.
- Reset, asynchronous and at any time including mid-access: state=IDLE, cnt=0, last_dm=0, latches=0, stall_cnt=0. All outputs are 0. An aborted access produces no ready.

## Timing
- Per access: 1 IDLE sampling cycle + MEM_LAT busy cycles. Ready is high in the last busy cycle.
- If the request is sampled at edge E, mem_en is high from E to E+MEM_LAT, and ready is high during the cycle ending at edge E+MEM_LAT.
- Back-to-back single port: one access every MEM_LAT+1 cycles.
- MEM_LAT=1: ready is high in the first and only busy cycle.
- Memory write takes effect on the edge ending the final BUSY_DM cycle, while mem_en=1 and mem_we=1.

## Test plan
- Reset then idle, MEM_LAT=2: all outputs 0, busy=0, stall_cnt=0 for 5 cycles.
- IF-only stream, if_addr 0x0,0x4,0x8, memory returning addr+0x100: if_ready every 3rd cycle, if_rdata 0x100/0x104/0x108, stall_cnt=6 after three fetches.
- Simultaneous if_req (0x10) and dm_req load (0x40): DM granted first, dm_rdata from 0x40. IF granted next even though dm_req is reasserted with a new address; that DM access is served third.
- Store dm_addr=0x20, wdata=0xDEADBEEF: mem_we=1 and mem_addr=0x20 for 2 cycles. A following load of 0x20 returns 0xDEADBEEF.
- rst pulsed in the first BUSY_DM cycle: mem_en drops immediately, no dm_ready. After release the held dm_req is re-granted with full latency.
- stall_cnt with CNT_W=4 under continuous requests: counts to 15 and holds.
